// File: rtl/delay_request_queue.sv
// delay_request_queue
//   Initiator side of a delay-timer start/enable/busy handshake. User action
//   requests are buffered in a small FIFO. One delay at a time is launched on
//   the external timer, and a completion pulse carrying the action code is
//   emitted when the timer's enable fires.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears all state immediately
//   req_valid  request present this cycle
//   req_code   action code of the request
//   req_ready  FIFO not full (forced low while in reset)
//   start      one-cycle launch pulse to the delay timer
//   busy       delay timer is counting
//   enable     delay timer expiry pulse
//   done       one-cycle completion pulse
//   done_code  code of the completed action; holds between pulses
//   pending    FIFO occupancy, not counting the in-flight entry
//   overflow   sticky: a request arrived while the FIFO was full
//   timeout    sticky: timer never acknowledged, or aborted without enable
module delay_request_queue #(
    parameter int DEPTH    = 4,
    parameter int CODE_W   = 2,
    parameter int ACK_WAIT = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_code,
    output logic              req_ready,
    output logic              start,
    input  logic              busy,
    input  logic              enable,
    output logic              done,
    output logic [CODE_W-1:0] done_code,
    output logic [CW-1:0]     pending,
    output logic              overflow,
    output logic              timeout
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(ACK_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_EN
    } state_t;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q;
    logic [CODE_W-1:0] cur_code_q, done_code_q;
    logic [WCW-1:0]    wait_cnt_q;
    logic              start_q, done_q, overflow_q, timeout_q;
    logic              full, push, pop;

    assign full = (count_q == CW'(DEPTH));
    // Gated with reset so every output reads 0 while reset is held.
    assign req_ready = reset & ~full;
    assign push      = req_valid & req_ready;
    // The timer holds busy through its enable cycle; wait for it to drop.
    assign pop       = (state_q == S_IDLE) && (count_q != '0) && !busy;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= req_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            // Judged on the registered full flag, so a same-cycle pop
            // does not rescue the request.
            if (req_valid && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cur_code_q  <= '0;
            done_code_q <= '0;
            wait_cnt_q  <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_code_q <= mem_q[rptr_q];
                        start_q    <= 1'b1;
                        state_q    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (busy) begin
                        state_q <= S_WAIT_EN;
                    end else if (wait_cnt_q == WCW'(ACK_WAIT - 1)) begin
                        // ACK_WAIT edges without busy: drop the action.
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                S_WAIT_EN: begin
                    if (enable) begin
                        done_q      <= 1'b1;
                        done_code_q <= cur_code_q;
                        state_q     <= S_IDLE;
                    end else if (!busy) begin
                        // Timer aborted without expiry.
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start     = start_q;
    assign done      = done_q;
    assign done_code = done_code_q;
    assign pending   = count_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_delay_request_queue.sv
module tb_delay_request_queue;

    localparam int DEPTH    = 4;
    localparam int CODE_W   = 2;
    localparam int ACK_WAIT = 4;
    localparam int N        = 10;

    localparam int M_NORMAL = 0;
    localparam int M_NOBUSY = 1;
    localparam int M_STALL  = 2;
    localparam int M_ABORT  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [CODE_W-1:0] req_code;
    logic              req_ready;
    logic              start;
    logic              busy;
    logic              enable;
    logic              done;
    logic [CODE_W-1:0] done_code;
    logic [2:0]        pending;
    logic              overflow;
    logic              timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = M_NORMAL;
    int tcnt;
    logic [CODE_W-1:0] exp_q[$];
    logic [CODE_W-1:0] mon_exp;

    delay_request_queue #(.DEPTH(DEPTH), .CODE_W(CODE_W), .ACK_WAIT(ACK_WAIT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code),
        .req_ready(req_ready), .start(start), .busy(busy), .enable(enable),
        .done(done), .done_code(done_code), .pending(pending),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Delay timer model: enable is high in the cycle N edges after start is
    // sampled, busy stays high through that cycle and one more.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0; enable <= 1'b0; tcnt <= 0;
        end else begin
            enable <= 1'b0;
            if (start && !busy && mode != M_NOBUSY) begin
                busy <= 1'b1; tcnt <= N + 2;
            end else if (busy && mode != M_STALL) begin
                tcnt <= tcnt - 1;
                if (mode == M_ABORT && tcnt == 6) busy <= 1'b0;
                else begin
                    enable <= (tcnt == 3);
                    if (tcnt == 1) busy <= 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every done pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (reset && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got code %0d, expected no done", done_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (done_code !== mon_exp) begin
                    errors++;
                    $display("FAIL done_code: got %0d expected %0d", done_code, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_done_code"}, done_code, 0);
    endtask

    task automatic settle(input string tag, input int extra);
        int n = 0;
        while ((busy || pending != 0 || start) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) chk({tag, "_settle_timeout"}, 1, 0);
        repeat (extra) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk); n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n, maxp, ndone, last_done, scyc, tcyc;
        logic [CODE_W-1:0] ord [3];
        logic [CODE_W-1:0] ovf [6];
        ord = '{2'd1, 2'd3, 2'd0};
        ovf = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset = 1'b0; req_valid = 1'b0; req_code = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("t1_ready", req_ready, 1);

        // 1. Single request
        req_valid = 1'b1; req_code = 2'd2; exp_q.push_back(2'd2);
        @(negedge clk); req_valid = 1'b0;
        chk("t1_pending_after_push", pending, 1);
        chk("t1_start_early", start, 0);
        @(negedge clk);
        chk("t1_start_high", start, 1);
        chk("t1_pending_after_pop", pending, 0);
        @(negedge clk);
        chk("t1_start_one_cycle", start, 0);
        n = 0;
        while (!enable && n < 50) begin @(negedge clk); n++; end
        chk("t1_enable_seen", enable, 1);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_done_code", done_code, 2);
        @(negedge clk);
        chk("t1_done_one_cycle", done, 0);
        chk("t1_pending_end", pending, 0);
        chk("t1_done_code_hold", done_code, 2);

        // 2. Queue ordering
        settle("t2", 3);
        maxp = 0; ndone = 0; last_done = 0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_code = ord[i]; exp_q.push_back(ord[i]);
            @(negedge clk);
            if (pending > maxp) maxp = pending;
        end
        req_valid = 1'b0;
        n = 0;
        while (ndone < 3 && n < 300) begin
            if (pending > maxp) maxp = pending;
            if (start && ndone > 0) chk("t2_start_gap", cyc - last_done, 2);
            if (done) begin ndone++; last_done = cyc; end
            @(negedge clk); n++;
        end
        chk("t2_ndone", ndone, 3);
        chk("t2_pending_peak", maxp, 2);
        chk("t2_pending_end", pending, 0);

        // 3. Overflow with the timer stalled busy
        settle("t3", 3);
        mode = M_STALL;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_code = ovf[i];
            if (i < 5) exp_q.push_back(ovf[i]);
            @(negedge clk);
            if (i == 4) begin
                chk("t3_ready_full", req_ready, 0);
                chk("t3_pending_full", pending, 4);
                chk("t3_no_overflow_yet", overflow, 0);
            end
        end
        req_valid = 1'b0;
        chk("t3_overflow", overflow, 1);
        chk("t3_pending_after_drop", pending, 4);
        mode = M_NORMAL;
        drain("t3");
        settle("t3b", 20);
        chk("t3_overflow_sticky", overflow, 1);
        reset_pulse("rst3");

        // 5a. Push while full in the same cycle as an IDLE pop
        mode = M_STALL;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_code = CODE_W'(i + 1); exp_q.push_back(CODE_W'(i + 1));
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("t5a_pending_full", pending, 4);
        mode = M_NORMAL;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("t5a_first_done", done, 1);
        chk("t5a_pending_at_done", pending, 4);
        @(negedge clk);
        req_valid = 1'b1; req_code = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5a_pop_start", start, 1);
        chk("t5a_pending_after_pop", pending, 3);
        chk("t5a_overflow", overflow, 1);
        drain("t5a");
        settle("t5a", 30);
        reset_pulse("rst5a");

        // 4a. Timer never raises busy
        mode = M_NOBUSY;
        req_valid = 1'b1; req_code = 2'd3;
        @(negedge clk);
        req_code = 2'd2; exp_q.push_back(2'd2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4a_start", start, 1);
        scyc = cyc;
        n = 0;
        while (!timeout && n < 20) begin @(negedge clk); n++; end
        tcyc = cyc;
        chk("t4a_timeout", timeout, 1);
        chk("t4a_timeout_latency", tcyc - (scyc + 1), ACK_WAIT);
        mode = M_NORMAL;
        @(negedge clk);
        chk("t4a_next_launch", start, 1);
        drain("t4a");
        settle("t4a", 10);
        chk("t4a_timeout_sticky", timeout, 1);
        reset_pulse("rst4a");

        // 4b. Timer aborts without enable
        mode = M_ABORT;
        req_valid = 1'b1; req_code = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!timeout && n < 60) begin @(negedge clk); n++; end
        chk("t4b_timeout", timeout, 1);
        settle("t4b", 20);
        mode = M_NORMAL;
        reset_pulse("rst4b");

        // 5b. Reset during WAIT_EN
        req_valid = 1'b1; req_code = 2'd0;
        @(negedge clk);
        req_code = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5b_busy", busy, 1);
        chk("t5b_pending", pending, 1);
        reset = 1'b0;
        #1;
        check_zero("t5b_async");
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("t5b_pending_after", pending, 0);
        chk("t5b_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
